// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and sizing helpers for the signed divider
//
// Purpose: default operand width, control FSM state encoding and the
// iteration-counter sizing rule shared by div_unit and its testbench.
// Ports: none (package).

package div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // Counter must hold the value WIDTH, hence one bit beyond log2.
  function automatic int cnt_width(input int w);
    return $clog2(w) + 1;
  endfunction

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring-division iteration
//
// Purpose: shift the next dividend bit into the partial remainder, trial-
// subtract the divisor, and restore if the subtraction would go negative.
// Ports:
//   rem_in   in  WIDTH  partial remainder before this step
//   dvd_msb  in  1      dividend bit being brought down
//   divisor  in  WIDTH  magnitude of the divisor
//   rem_out  out WIDTH  partial remainder after this step
//   q_bit    out 1      quotient bit produced by this step

module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dvd_msb,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  always_comb begin
    shifted = {rem_in, dvd_msb};
    diff    = shifted - {1'b0, divisor};
    // rem_in < divisor <= 2^(WIDTH-1) (or rem_in is a dividend prefix when
    // the divisor is zero), so shifted < 2^WIDTH and bit WIDTH of the
    // difference is a clean borrow/sign flag.
    q_bit   = ~diff[WIDTH];
    rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/div_unit.sv
// rtl/div_unit.sv - multicycle signed restoring divider (quotient->lo, remainder->hi)
//
// Purpose: MIPS DIV. Operands are converted to magnitudes on start, WIDTH
// restoring steps run one per cycle, then signs are applied and hi/lo/done
// are registered together. Optional macro DIV_ZERO_EXC_EN: a zero divisor
// skips the iteration and pulses divZero instead of producing a result.
// Ports:
//   clk      in   1      rising-edge clock
//   reset    in   1      synchronous active-high reset
//   start    in   1      divide strobe, sampled only in IDLE
//   a        in   WIDTH  signed dividend
//   b        in   WIDTH  signed divisor
//   hi       out  WIDTH  remainder, held until next completion
//   lo       out  WIDTH  quotient, held until next completion
//   busy     out  1      operation in flight (RUN or FIX)
//   done     out  1      one-cycle pulse, hi/lo newly updated
//   divZero  out  1      one-cycle divide-by-zero pulse (DIV_ZERO_EXC_EN only)

module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             divZero
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             divzero_q, divzero_d;

  logic [WIDTH-1:0] step_rem;
  logic             step_qbit;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .dvd_msb (dvd_q[WIDTH-1]),
    .divisor (dvs_q),
    .rem_out (step_rem),
    .q_bit   (step_qbit)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    dvd_d     = dvd_q;
    dvs_d     = dvs_q;
    quo_d     = quo_q;
    qneg_d    = qneg_q;
    rneg_d    = rneg_q;
    dz_d      = dz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    divzero_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          // Negation of the most-negative value wraps to 2^(W-1), which is
          // exactly the unsigned magnitude wanted.
          dvd_d  = a[WIDTH-1] ? -a : a;
          dvs_d  = b[WIDTH-1] ? -b : b;
          qneg_d = a[WIDTH-1] ^ b[WIDTH-1];
          rneg_d = a[WIDTH-1];
          rem_d  = '0;
          quo_d  = '0;
          cnt_d  = '0;
          dz_d   = 1'b0;
          state_d = RUN;
`ifdef DIV_ZERO_EXC_EN
          if (b == '0) begin
            dz_d      = 1'b1;
            divzero_d = 1'b1;
            state_d   = FIX;
          end
`else
          // Zero divisor yields an all-ones quotient regardless of the
          // dividend's sign.
          if (b == '0) begin
            qneg_d = 1'b0;
          end
`endif
        end
      end
      RUN: begin
        rem_d = step_rem;
        dvd_d = dvd_q << 1;
        quo_d = {quo_q[WIDTH-2:0], step_qbit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
        if (!dz_q) begin
          lo_d   = qneg_q ? -quo_q : quo_q;
          hi_d   = rneg_q ? -rem_q : rem_q;
          done_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      rem_q     <= '0;
      dvd_q     <= '0;
      dvs_q     <= '0;
      quo_q     <= '0;
      qneg_q    <= 1'b0;
      rneg_q    <= 1'b0;
      dz_q      <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
      divzero_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rem_q     <= rem_d;
      dvd_q     <= dvd_d;
      dvs_q     <= dvs_d;
      quo_q     <= quo_d;
      qneg_q    <= qneg_d;
      rneg_q    <= rneg_d;
      dz_q      <= dz_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
      divzero_q <= divzero_d;
    end
  end

  assign hi      = hi_q;
  assign lo      = lo_q;
  assign busy    = (state_q == RUN) || (state_q == FIX);
  assign done    = done_q;
  assign divZero = divzero_q;

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - directed self-checking bench for div_unit

module tb_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;
  logic        div_zero;

  int checks = 0;
  int errors = 0;

  div_unit #(.WIDTH(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .hi      (hi),
    .lo      (lo),
    .busy    (busy),
    .done    (done),
    .divZero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one operation and count edges after the start edge until done.
  // lat = 0 means done never appeared within the budget.
  task automatic run_op(input logic [31:0] aa, input logic [31:0] bb,
                        output int lat, output logic busy_early);
    a = aa; b = bb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_early = busy;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi got %h want %h", hi, 32'h0); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo got %h want %h", lo, 32'h0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_divzero got %b want 0", div_zero); end
  endtask

  task automatic test_basic;
    int lat; logic be;
    run_op(32'd7, 32'd2, lat, be);
    checks++; if (be !== 1'b1) begin errors++; $display("FAIL basic_busy got %b want 1", be); end
    checks++; if (lat !== 33) begin errors++; $display("FAIL basic_latency got %0d want 33", lat); end
    checks++; if (lo !== 32'h3) begin errors++; $display("FAIL basic_lo got %h want %h", lo, 32'h3); end
    checks++; if (hi !== 32'h1) begin errors++; $display("FAIL basic_hi got %h want %h", hi, 32'h1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_at_done got %b want 0", busy); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b want 0", busy); end
  endtask

  task automatic test_signs;
    int lat; logic be;
    run_op(32'hFFFF_FFF9, 32'd2, lat, be);
    checks++; if (lat !== 33) begin errors++; $display("FAIL negdvd_latency got %0d want 33", lat); end
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL negdvd_lo got %h want %h", lo, 32'hFFFF_FFFD); end
    checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL negdvd_hi got %h want %h", hi, 32'hFFFF_FFFF); end
    @(posedge clk); #1;
    run_op(32'd7, 32'hFFFF_FFFE, lat, be);
    checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL negdvs_lo got %h want %h", lo, 32'hFFFF_FFFD); end
    checks++; if (hi !== 32'h1) begin errors++; $display("FAIL negdvs_hi got %h want %h", hi, 32'h1); end
  endtask

  task automatic test_overflow;
    int lat; logic be;
    @(posedge clk); #1;
    run_op(32'h8000_0000, 32'hFFFF_FFFF, lat, be);
    checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL ovf_lo got %h want %h", lo, 32'h8000_0000); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL ovf_hi got %h want %h", hi, 32'h0); end
    @(posedge clk); #1;
    run_op(32'h8000_0000, 32'h1, lat, be);
    checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL minby1_lo got %h want %h", lo, 32'h8000_0000); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL minby1_hi got %h want %h", hi, 32'h0); end
  endtask

  task automatic test_back_to_back;
    int lat; logic be;
    // Still in the done cycle of the previous op: start again immediately.
    run_op(32'd100, 32'd9, lat, be);
    checks++; if (lat !== 33) begin errors++; $display("FAIL b2b_latency got %0d want 33", lat); end
    checks++; if (lo !== 32'd11) begin errors++; $display("FAIL b2b_lo got %h want %h", lo, 32'd11); end
    checks++; if (hi !== 32'd1) begin errors++; $display("FAIL b2b_hi got %h want %h", hi, 32'd1); end
    run_op(32'd0, 32'd13, lat, be);
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL zerodvd_lo got %h want %h", lo, 32'h0); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL zerodvd_hi got %h want %h", hi, 32'h0); end
  endtask

  task automatic test_div_zero;
    @(posedge clk); #1;
`ifdef DIV_ZERO_EXC_EN
    // hi/lo currently hold the 0/13 result (both zero); seed a known value.
    begin
      int lat; logic be;
      run_op(32'd50, 32'd8, lat, be);
    end
    a = 32'd5; b = 32'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL dz_pulse got %b want 1", div_zero); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL dz_busy got %b want 1", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL dz_done got %b want 0", done); end
    @(posedge clk); #1;
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL dz_pulse_end got %b want 0", div_zero); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dz_busy_end got %b want 0", busy); end
    checks++; if (lo !== 32'd6) begin errors++; $display("FAIL dz_lo_kept got %h want %h", lo, 32'd6); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL dz_hi_kept got %h want %h", hi, 32'd2); end
`else
    begin
      int lat; logic be;
      run_op(32'd5, 32'd0, lat, be);
      checks++; if (lat !== 33) begin errors++; $display("FAIL dz_latency got %0d want 33", lat); end
      checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_lo got %h want %h", lo, 32'hFFFF_FFFF); end
      checks++; if (hi !== 32'd5) begin errors++; $display("FAIL dz_hi got %h want %h", hi, 32'd5); end
      checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL dz_flag got %b want 0", div_zero); end
    end
`endif
  endtask

  task automatic test_start_while_busy;
    int lat;
    @(posedge clk); #1;
    a = 32'd100; b = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 10) begin
        a = 32'd1; b = 32'd1; start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (done) begin
        lat = k;
        break;
      end
    end
    checks++; if (lat !== 33) begin errors++; $display("FAIL busy_start_latency got %0d want 33", lat); end
    checks++; if (lo !== 32'd14) begin errors++; $display("FAIL busy_start_lo got %h want %h", lo, 32'd14); end
    checks++; if (hi !== 32'd2) begin errors++; $display("FAIL busy_start_hi got %h want %h", hi, 32'd2); end
  endtask

  task automatic test_reset_mid_op;
    int lat; logic be; logic saw_done;
    @(posedge clk); #1;
    a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %b want 0", busy); end
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL midrst_hi got %h want %h", hi, 32'h0); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL midrst_lo got %h want %h", lo, 32'h0); end
    saw_done = 1'b0;
    for (int k = 0; k < 25; k++) begin
      if (done) saw_done = 1'b1;
      @(posedge clk); #1;
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL midrst_no_done got %b want 0", saw_done); end
    run_op(32'd9, 32'd3, lat, be);
    checks++; if (lat !== 33) begin errors++; $display("FAIL midrst_fresh_latency got %0d want 33", lat); end
    checks++; if (lo !== 32'd3) begin errors++; $display("FAIL midrst_fresh_lo got %h want %h", lo, 32'd3); end
    checks++; if (hi !== 32'd0) begin errors++; $display("FAIL midrst_fresh_hi got %h want %h", hi, 32'd0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_overflow();
    test_back_to_back();
    test_div_zero();
    test_start_while_busy();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
